// File: rtl/osc_monitor_pkg.sv
// rtl/osc_monitor_pkg.sv - shared types and helpers for the oscillator monitor
package osc_monitor_pkg;

    // Selector states: no usable channel, locked onto one, or re-choosing for one cycle
    typedef enum logic [1:0] {
        ST_NONE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_SWITCH = 2'd2
    } sel_state_t;

    // Consecutive good windows needed before a channel is declared OK
    localparam int STREAK_NEED = 2;

    // Index of the lowest set bit; 0 when no bit is set
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/osc_chan_meas.sv
// rtl/osc_chan_meas.sv - per-channel synchroniser, edge counter and health flag
module osc_chan_meas
    import osc_monitor_pkg::*;
#(
    parameter int               CNT_W  = 16,
    parameter logic [CNT_W-1:0] LO_LIM = '0,
    parameter logic [CNT_W-1:0] HI_LIM = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             osc,
    input  logic             terminal,
    output logic [CNT_W-1:0] meas,
    output logic             ok
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       STREAK_T = 2'(STREAK_NEED);

    logic             sync1;
    logic             sync2;
    logic             sync_d;
    logic             edge_det;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] win_cnt;
    logic             good;
    logic [1:0]       streak;
    logic [1:0]       streak_next;

    // Two-flop synchroniser plus one delay stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= osc;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign edge_det = sync2 & ~sync_d;

    // Count including this cycle's edge, saturating; also what the terminal cycle captures
    assign win_cnt = (edge_det && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;

    // Written as > / == so the bounds stay meaningful at the extremes of the range
    assign good = ((win_cnt > LO_LIM) || (win_cnt == LO_LIM)) &&
                  ((win_cnt < HI_LIM) || (win_cnt == HI_LIM));

    // Streak of good windows, saturating at the threshold; one bad window clears it
    always_comb begin
        streak_next = 2'd0;
        if (good) begin
            streak_next = (streak == STREAK_T) ? streak : streak + 2'd1;
        end
    end

    // Edge counter, window capture and health flag update
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            meas   <= '0;
            streak <= 2'd0;
            ok     <= 1'b0;
        end else if (terminal) begin
            cnt    <= '0;
            meas   <= win_cnt;
            streak <= streak_next;
            ok     <= (streak_next == STREAK_T);
        end else begin
            cnt    <= win_cnt;
        end
    end

endmodule

// File: rtl/osc_monitor.sv
// rtl/osc_monitor.sv - multi-channel oscillator frequency monitor with failover selector
module osc_monitor
    import osc_monitor_pkg::*;
#(
    parameter int                   NCH         = 3,
    parameter int                   CNT_W       = 16,
    parameter int                   GATE_CYCLES = 1000,
    parameter logic [NCH*CNT_W-1:0] LO_LIM      = '0,
    parameter logic [NCH*CNT_W-1:0] HI_LIM      = '1,
    parameter bit                   REVERT      = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NCH-1:0]       OSC_IN,
    output logic [NCH*CNT_W-1:0] MEAS,
    output logic                 MEAS_VALID,
    output logic [NCH-1:0]       CH_OK,
    output logic [2:0]           SEL,
    output logic                 SEL_VALID,
    output logic                 FAIL_EVT
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    logic [GATE_W-1:0] gate_cnt;
    logic              terminal;
    logic [7:0]        ok8;
    logic [2:0]        low_idx;
    logic              any_ok;
    sel_state_t        state;
    sel_state_t        next_state;
    logic [2:0]        next_sel;
    logic              fail_now;

    assign terminal = (gate_cnt == '0);

    // Gate counter: counts down, reloads after the terminal cycle and on reset
    always_ff @(posedge CLK) begin
        if (RESET || terminal) begin
            gate_cnt <= GATE_LOAD;
        end else begin
            gate_cnt <= gate_cnt - GATE_W'(1);
        end
    end

    // MEAS_VALID follows the terminal cycle so it lines up with the captured counts
    always_ff @(posedge CLK) begin
        if (RESET) begin
            MEAS_VALID <= 1'b0;
        end else begin
            MEAS_VALID <= terminal;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        osc_chan_meas #(
            .CNT_W  (CNT_W),
            .LO_LIM (LO_LIM[i*CNT_W +: CNT_W]),
            .HI_LIM (HI_LIM[i*CNT_W +: CNT_W])
        ) u_meas (
            .clk      (CLK),
            .reset    (RESET),
            .osc      (OSC_IN[i]),
            .terminal (terminal),
            .meas     (MEAS[i*CNT_W +: CNT_W]),
            .ok       (CH_OK[i])
        );
    end

    // Widen the health flags to 8 bits so SEL can index them for any NCH
    always_comb begin
        ok8 = 8'd0;
        ok8[NCH-1:0] = CH_OK;
    end

    assign low_idx = lowest_set(ok8);
    assign any_ok  = |CH_OK;

    // Selector next-state: lock on lowest OK channel, fail over on loss, optional revert
    always_comb begin
        next_state = state;
        next_sel   = SEL;
        fail_now   = 1'b0;
        case (state)
            ST_NONE: begin
                if (any_ok) begin
                    next_state = ST_LOCKED;
                    next_sel   = low_idx;
                end
            end
            ST_LOCKED: begin
                if (!ok8[SEL]) begin
                    next_state = ST_SWITCH;
                    fail_now   = 1'b1;
                end else if (REVERT && (low_idx < SEL)) begin
                    next_state = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (any_ok) begin
                    next_state = ST_LOCKED;
                    next_sel   = low_idx;
                end else begin
                    next_state = ST_NONE;
                end
            end
            default: begin
                next_state = ST_NONE;
            end
        endcase
    end

    // Selector state and selected-channel registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_NONE;
            SEL   <= 3'd0;
        end else begin
            state <= next_state;
            SEL   <= next_sel;
        end
    end

    assign SEL_VALID = (state == ST_LOCKED) && ok8[SEL];
    assign FAIL_EVT  = fail_now && !RESET;

endmodule

// File: doc/osc_monitor.md
OSC_MONITOR -- requirements
Module: osc_monitor

Interface
REQ-001 The block SHALL have parameter NCH, default 3, the number of monitored oscillator channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, the width of the edge counter and limits.
REQ-003 The block SHALL have parameter GATE_CYCLES, default 1000, the measurement window length in CLK cycles (>=4).
REQ-004 The block SHALL have parameters LO_LIM and HI_LIM, each NCH*CNT_W bits, default all channels 0 / all ones, giving per-channel inclusive count bounds; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-005 The block SHALL have parameter REVERT, default 0; when 1, selection returns to a lower-index channel once it becomes OK again.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port OSC_IN, input, NCH bits: the raw oscillator outputs, asynchronous to CLK.
REQ-009 The block SHALL have port MEAS, output, NCH*CNT_W bits: the last completed window count per channel.
REQ-010 The block SHALL have port MEAS_VALID, output, 1 bit: a one-cycle pulse when MEAS updates.
REQ-011 The block SHALL have port CH_OK, output, NCH bits: the per-channel health flags.
REQ-012 The block SHALL have port SEL, output, 3 bits: the index of the selected healthy channel.
REQ-013 The block SHALL have port SEL_VALID, output, 1 bit: high when SEL names an OK channel.
REQ-014 The block SHALL have port FAIL_EVT, output, 1 bit: a one-cycle pulse when the selected channel fails.

Function
REQ-015 Each OSC_IN bit SHALL pass through a 2-flop synchroniser followed by a rising-edge detector; the CLK frequency SHALL exceed 2.5x the highest monitored frequency (system constraint, not checked).
REQ-016 The gate counter SHALL run from GATE_CYCLES-1 down to 0 and reload, with the terminal cycle at count 0.
REQ-017 Each per-channel edge counter SHALL increment on a detected edge and saturate at 2^CNT_W-1.
REQ-018 On the terminal cycle, MEAS[i] SHALL load the counter value plus any edge detected that same cycle (saturating), the counter SHALL clear to 0, and MEAS_VALID SHALL pulse one cycle later, aligned with the updated MEAS.
REQ-019 A window SHALL be good when LO_LIM[i] <= count <= HI_LIM[i].
REQ-020 CH_OK[i] SHALL set after 2 consecutive good windows and clear after 1 bad window; CH_OK SHALL update in the same cycle as MEAS_VALID.
REQ-021 The selector FSM SHALL have three states: NONE (SEL_VALID=0), LOCKED (SEL_VALID=1), and SWITCH (one cycle, SEL_VALID=0, SEL updating).
REQ-022 NONE SHALL go to LOCKED, with SEL set to the lowest-index OK channel, on the first cycle any CH_OK bit is 1.
REQ-023 LOCKED SHALL go to SWITCH when CH_OK[SEL] clears, pulsing FAIL_EVT in that cycle.
REQ-024 SWITCH SHALL go to LOCKED, with SEL set to the lowest-index OK channel, if any channel is OK; otherwise it SHALL go to NONE with SEL held.
REQ-025 With REVERT=1, if in LOCKED a lower-index channel becomes OK, the FSM SHALL go to SWITCH without a FAIL_EVT pulse; with REVERT=0, SEL SHALL be held while the selected channel stays OK.
REQ-026 A simultaneous failure of the selected channel and recovery of another channel SHALL be resolved by REQ-023/REQ-024 using the updated CH_OK values.

Reset
REQ-027 While RESET is high, the synchronisers, edge counters, and good-streak counters SHALL clear to 0, the gate counter SHALL load GATE_CYCLES-1, and the FSM SHALL enter NONE.
REQ-028 While RESET is high, the outputs SHALL be MEAS=0, MEAS_VALID=0, CH_OK=0, SEL=0, SEL_VALID=0, and FAIL_EVT=0.
REQ-029 A RESET asserted mid-window SHALL discard the partial counts, and the first window after release SHALL be a full GATE_CYCLES long.

Structure
REQ-030 The FSM state encoding and a lowest-set-bit priority function SHALL live in package osc_monitor_pkg.
REQ-031 The per-channel synchroniser, edge detector, saturating counter, and good-streak logic SHALL be one sub-module, osc_chan_meas, instantiated NCH times.

Verification
REQ-032 The bench SHALL use NCH=3, GATE_CYCLES=100, and limits 9..11 on all channels.
REQ-033 Scenario: all channels toggle with period 10 CLK -> MEAS=10 each window; CH_OK=3'b111 after the 2nd MEAS_VALID; SEL=0; SEL_VALID=1.
REQ-034 Scenario: channel 0 is stopped while LOCKED on channel 0 -> at the next MEAS_VALID, CH_OK[0]=0 and FAIL_EVT pulses, then after one SWITCH cycle SEL=1.
REQ-035 Scenario: channel 0 is restored while LOCKED on channel 1 -> with REVERT=0, SEL stays 1; with REVERT=1, SEL=0 two windows later with no FAIL_EVT.
REQ-036 Scenario: all channels are stopped -> FSM in NONE with SEL_VALID=0; restarting channel 2 only -> SEL=2 and SEL_VALID=1 after 2 good windows.
REQ-037 Scenario: channel 1 toggles with period 2 and CNT_W=5 -> MEAS saturates at 31, the window is bad, and CH_OK[1]=0.
REQ-038 Scenario: RESET is pulsed at gate count 50 -> all outputs are 0 in the following cycle, and the next MEAS_VALID occurs exactly 101 cycles after RESET deasserts.
